pattern_classifier: RTL

- Downstream consumer of the generator stage of top_level.
- Captures the 3x3 Q8.24 generated image on each gen_finish pulse.
- Scans the nine pixels serially, one per clock. Each pixel is thresholded into a 9-bit binary mask and added into a signed pixel sum.
- Classifies the mask against CIRCLE and CROSS templates by Hamming distance and reports the result with a one-cycle valid pulse.

---
 rtl/pattern_classifier.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/pattern_classifier.sv
// pattern_classifier
//   Captures a 3x3 signed Q8.24 image on a gen_finish strobe, scans the nine
//   pixels one per clock into a threshold mask and a signed sum, then scores
//   the mask against circle/cross templates by Hamming distance.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   gen_finish            single-cycle strobe, pixel inputs hold a frame
//   pixel_1x1..pixel_3x3  signed pixels, row-major
//   busy                  frame in flight (SCAN/EVAL)
//   result_valid          one-cycle pulse when result outputs update
//   mask                  thresholded image, bit0=1x1 .. bit8=3x3
//   dist_circle/cross     Hamming distance of mask to each template
//   class_id              0=none 1=circle 2=cross 3=tie
//   pixel_sum             signed sum of the nine pixels, WIDTH+4 bits
//   overrun               sticky, gen_finish seen while busy
//
// state | meaning
// IDLE  | waiting for gen_finish, results held
// SCAN  | one buffered pixel per clock, idx 0..8
// EVAL  | register mask, distances, class and sum
module pattern_classifier #(
  parameter int                       WIDTH      = 32,
  parameter logic signed [WIDTH-1:0]  THRESH     = 32'h00800000,
  parameter logic [8:0]               TPL_CIRCLE = 9'h1EF,
  parameter logic [8:0]               TPL_CROSS  = 9'h155,
  parameter int                       MAX_DIST   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               gen_finish,
  input  logic [WIDTH-1:0]   pixel_1x1,
  input  logic [WIDTH-1:0]   pixel_1x2,
  input  logic [WIDTH-1:0]   pixel_1x3,
  input  logic [WIDTH-1:0]   pixel_2x1,
  input  logic [WIDTH-1:0]   pixel_2x2,
  input  logic [WIDTH-1:0]   pixel_2x3,
  input  logic [WIDTH-1:0]   pixel_3x1,
  input  logic [WIDTH-1:0]   pixel_3x2,
  input  logic [WIDTH-1:0]   pixel_3x3,
  output logic               busy,
  output logic               result_valid,
  output logic [8:0]         mask,
  output logic [3:0]         dist_circle,
  output logic [3:0]         dist_cross,
  output logic [1:0]         class_id,
  output logic [WIDTH+3:0]   pixel_sum,
  output logic               overrun
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_EVAL} state_t;

  localparam logic [3:0] MAX_D = 4'(MAX_DIST);

  state_t                    state_q, state_d;
  logic [WIDTH-1:0]          pix_q [9];
  logic [WIDTH-1:0]          pix_in [9];
  logic [3:0]                idx_q;
  logic [8:0]                mask_acc_q;
  logic signed [WIDTH+3:0]   sum_acc_q;

  logic [8:0]                mask_q;
  logic [3:0]                dc_q, dx_q;
  logic [1:0]                cls_q;
  logic [WIDTH+3:0]          sum_q;
  logic                      valid_q, ovr_q;

  logic                      start, scan_en, eval_en;
  logic signed [WIDTH-1:0]   cur_pix;
  logic [3:0]                dist_c, dist_x;
  logic [1:0]                cls_d;

  function automatic logic [3:0] popcnt9(input logic [8:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 9; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  always_comb begin
    pix_in[0] = pixel_1x1; pix_in[1] = pixel_1x2; pix_in[2] = pixel_1x3;
    pix_in[3] = pixel_2x1; pix_in[4] = pixel_2x2; pix_in[5] = pixel_2x3;
    pix_in[6] = pixel_3x1; pix_in[7] = pixel_3x2; pix_in[8] = pixel_3x3;
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (gen_finish) state_d = S_SCAN;
      S_SCAN:  if (idx_q == 4'd8) state_d = S_EVAL;
      S_EVAL:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy    = (state_q != S_IDLE);
    start   = (state_q == S_IDLE) && gen_finish;
    scan_en = (state_q == S_SCAN);
    eval_en = (state_q == S_EVAL);
  end

  // classification of the completed mask
  always_comb begin
    logic qc, qx;
    cur_pix = pix_q[idx_q];
    dist_c  = popcnt9(mask_acc_q ^ TPL_CIRCLE);
    dist_x  = popcnt9(mask_acc_q ^ TPL_CROSS);
    qc      = (dist_c <= MAX_D);
    qx      = (dist_x <= MAX_D);
    cls_d   = 2'd0;
    if (qc && qx) begin
      if (dist_c < dist_x)      cls_d = 2'd1;
      else if (dist_x < dist_c) cls_d = 2'd2;
      else                      cls_d = 2'd3;
    end else if (qc) begin
      cls_d = 2'd1;
    end else if (qx) begin
      cls_d = 2'd2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 9; i++) pix_q[i] <= '0;
      idx_q      <= '0;
      mask_acc_q <= '0;
      sum_acc_q  <= '0;
      mask_q     <= '0;
      dc_q       <= '0;
      dx_q       <= '0;
      cls_q      <= '0;
      sum_q      <= '0;
      valid_q    <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      // EVAL counts as busy, so a strobe on the result edge is also an overrun
      if (gen_finish && busy) ovr_q <= 1'b1;
      if (start) begin
        for (int i = 0; i < 9; i++) pix_q[i] <= pix_in[i];
        idx_q      <= '0;
        mask_acc_q <= '0;
        sum_acc_q  <= '0;
      end
      if (scan_en) begin
        mask_acc_q[idx_q] <= (cur_pix > THRESH);
        sum_acc_q         <= sum_acc_q + {{4{cur_pix[WIDTH-1]}}, cur_pix};
        idx_q             <= idx_q + 4'd1;
      end
      if (eval_en) begin
        mask_q  <= mask_acc_q;
        dc_q    <= dist_c;
        dx_q    <= dist_x;
        cls_q   <= cls_d;
        sum_q   <= sum_acc_q;
        valid_q <= 1'b1;
      end
    end
  end

  assign result_valid = valid_q;
  assign mask         = mask_q;
  assign dist_circle  = dc_q;
  assign dist_cross   = dx_q;
  assign class_id     = cls_q;
  assign pixel_sum    = sum_q;
  assign overrun      = ovr_q;

endmodule
